intc_select_unit: RTL and testbench

INTC_SELECT_UNIT -- requirements
Module: intc_select_unit

---
 rtl/intc_select_unit.sv | 73 +++++++
 tb/tb_intc_select_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/intc_select_unit.sv
// Interrupt-controller select unit: ISR vector mux and IACK clear decoder, both combinational, plus a
// 1-cycle registered read port over a 16-byte window; no flow control, so a new address is accepted every cycle.
module intc_select_unit #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        priority_select,
    input  logic              IACK,
    input  logic [DATA_W-1:0] isr_addr0,
    input  logic [DATA_W-1:0] isr_addr1,
    input  logic [DATA_W-1:0] isr_addr2,
    input  logic [DATA_W-1:0] isr_addr3,
    input  logic [DATA_W-1:0] input_addr,
    input  logic [DATA_W-1:0] read_reg0,
    input  logic [DATA_W-1:0] read_reg1,
    input  logic [DATA_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_reg3,
    output logic [DATA_W-1:0] isr_addr,
    output logic [3:0]        reset,
    output logic [DATA_W-1:0] read_data,
    output logic              read_hit
);

    function automatic logic [DATA_W-1:0] mux4(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] c,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] y;
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
        return y;
    endfunction

    logic              hit;
    logic [DATA_W-1:0] word;
    logic              unused_byte_offset;

    assign isr_addr = mux4(priority_select, isr_addr0, isr_addr1, isr_addr2, isr_addr3);

    // Clear strobes deliberately ignore rst so an acknowledge during reset still clears its status bit.
    always_comb begin
        reset = 4'b0000;
        if (IACK) begin
            reset[priority_select] = 1'b1;
        end
    end

    // Byte offsets within a word return the whole word.
    assign unused_byte_offset = ^input_addr[1:0];

    assign hit  = (input_addr[DATA_W-1:4] == BASE_ADDR[DATA_W-1:4]);
    assign word = mux4(input_addr[3:2], read_reg0, read_reg1, read_reg2, read_reg3);

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
            read_hit  <= 1'b0;
        end else begin
            read_data <= hit ? word : '0;
            read_hit  <= hit;
        end
    end

endmodule

// File: tb/tb_intc_select_unit.sv
// Directed bench for intc_select_unit: table-driven mux/decoder and read-port vectors plus reset sequences.
module tb_intc_select_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  priority_select;
    logic        IACK;
    logic [31:0] isr_addr0, isr_addr1, isr_addr2, isr_addr3;
    logic [31:0] input_addr;
    logic [31:0] read_reg0, read_reg1, read_reg2, read_reg3;
    logic [31:0] isr_addr;
    logic [3:0]  reset;
    logic [31:0] read_data;
    logic        read_hit;

    int checks   = 0;
    int failures = 0;

    intc_select_unit #(.DATA_W(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .priority_select (priority_select),
        .IACK            (IACK),
        .isr_addr0       (isr_addr0),
        .isr_addr1       (isr_addr1),
        .isr_addr2       (isr_addr2),
        .isr_addr3       (isr_addr3),
        .input_addr      (input_addr),
        .read_reg0       (read_reg0),
        .read_reg1       (read_reg1),
        .read_reg2       (read_reg2),
        .read_reg3       (read_reg3),
        .isr_addr        (isr_addr),
        .reset           (reset),
        .read_data       (read_data),
        .read_hit        (read_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  psel;
        logic        iack;
        logic [31:0] exp_isr;
        logic [3:0]  exp_clr;
    } comb_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_hit;
    } read_vec_t;

    comb_vec_t cv[8];
    read_vec_t rv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cv[0] = '{2'd0, 1'b0, 32'h100, 4'b0000};
        cv[1] = '{2'd1, 1'b0, 32'h200, 4'b0000};
        cv[2] = '{2'd2, 1'b0, 32'h300, 4'b0000};
        cv[3] = '{2'd3, 1'b0, 32'h400, 4'b0000};
        cv[4] = '{2'd0, 1'b1, 32'h100, 4'b0001};
        cv[5] = '{2'd1, 1'b1, 32'h200, 4'b0010};
        cv[6] = '{2'd2, 1'b1, 32'h300, 4'b0100};
        cv[7] = '{2'd3, 1'b1, 32'h400, 4'b1000};

        rv[0] = '{32'h0000_0000, 32'hA0, 1'b1};
        rv[1] = '{32'h0000_0004, 32'hB1, 1'b1};
        rv[2] = '{32'h0000_0008, 32'hC2, 1'b1};
        rv[3] = '{32'h0000_000C, 32'hD3, 1'b1};
        rv[4] = '{32'h0000_0010, 32'h00, 1'b0};
        rv[5] = '{32'h0000_0007, 32'hB1, 1'b1};
        rv[6] = '{32'h0000_000E, 32'hD3, 1'b1};
        rv[7] = '{32'hFFFF_FFF0, 32'h00, 1'b0};

        isr_addr0 = 32'h100; isr_addr1 = 32'h200; isr_addr2 = 32'h300; isr_addr3 = 32'h400;
        read_reg0 = 32'hA0;  read_reg1 = 32'hB1;  read_reg2 = 32'hC2;  read_reg3 = 32'hD3;

        // Reset held two cycles over a valid in-window address; acknowledge still strobes.
        rst = 1'b1; IACK = 1'b1; priority_select = 2'd3; input_addr = 32'h8;
        #1;
        check("rst_clear_strobe", {28'h0, reset}, 32'h8);
        check("rst_isr_addr", isr_addr, 32'h400);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_read_data", read_data, 32'h0);
            check("rst_read_hit", {31'h0, read_hit}, 32'h0);
            check("rst_clear_strobe_hold", {28'h0, reset}, 32'h8);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_read_data", read_data, 32'hC2);
        check("post_rst_read_hit", {31'h0, read_hit}, 32'h1);

        foreach (cv[i]) begin
            priority_select = cv[i].psel;
            IACK = cv[i].iack;
            #1;
            check($sformatf("isr_mux_%0d", i), isr_addr, cv[i].exp_isr);
            check($sformatf("clear_dec_%0d", i), {28'h0, reset}, {28'h0, cv[i].exp_clr});
            check($sformatf("clear_onehot0_%0d", i), {31'h0, $onehot0(reset)}, 32'h1);
        end
        IACK = 1'b0;

        // Back-to-back addresses, one per cycle, each checked one cycle later.
        foreach (rv[i]) begin
            input_addr = rv[i].addr;
            @(posedge clk); #1;
            check($sformatf("read_data_%0d", i), read_data, rv[i].exp_data);
            check($sformatf("read_hit_%0d", i), {31'h0, read_hit}, {31'h0, rv[i].exp_hit});
        end

        // Output must stay registered: changing the address mid-cycle must not move read_data.
        input_addr = 32'h4;
        @(posedge clk); #1;
        input_addr = 32'h10;
        #2;
        check("read_data_registered", read_data, 32'hB1);
        @(posedge clk); #1;
        check("read_data_outside", read_data, 32'h0);

        // Reset mid-stream takes priority over a valid read.
        input_addr = 32'h0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_read_data", read_data, 32'h0);
        check("midrst_read_hit", {31'h0, read_hit}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_release_data", read_data, 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
